// File: rtl/adc_datain_acq.sv
// adc_datain_acq: ADC acquisition front end on the 240 MHz PLL output clock.
// Captures a programmed number of samples after a trigger rise into a
// 16-deep show-ahead FIFO streamed out over valid/ready.
// Optional build macro ADC_DATAIN_TESTPATTERN_EN replaces the ADC data with
// a ramp counter that restarts at 0 for every acquisition.
module adc_datain_acq #(
    parameter int DATA_W  = 12,
    parameter int CNT_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              trig,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              lock_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                lock_meta_q, lock_q;
    logic                trig_q;
    logic [DATA_W-1:0]   d1_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                overflow_q, overflow_d;
    logic                lock_err_q, lock_err_d;
    logic                busy_q, done_q;
    logic [DATA_W:0]     mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    count_q;

    logic                trig_rise_s, pop_s, space_s, push_try_s, push_ok_s, arm_s;

    assign trig_rise_s = trig & ~trig_q;
    assign pop_s       = m_valid & m_ready;
    // A full FIFO can still take a sample when the head leaves in the same cycle.
    assign space_s     = (count_q < DEPTH_C) | pop_s;
    assign push_ok_s   = push_try_s & space_s;

    // Two-flop synchronizer for the asynchronous PLL lock and trigger edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_q      <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_q      <= lock_meta_q;
            trig_q      <= trig;
        end
    end

`ifdef ADC_DATAIN_TESTPATTERN_EN
    logic [DATA_W-1:0] ramp_q, ramp_d;
    localparam logic [DATA_W-1:0] RAMP_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    // Ramp restarts on arming and advances on every capture attempt.
    always_comb begin
        ramp_d = ramp_q;
        if (arm_s) begin
            ramp_d = {DATA_W{1'b0}};
        end else if (push_try_s) begin
            ramp_d = ramp_q + RAMP_ONE;
        end else begin
            ramp_d = ramp_q;
        end
    end

    // Sample register fed by the ramp's next value so the first capture is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q <= {DATA_W{1'b0}};
            d1_q   <= {DATA_W{1'b0}};
        end else begin
            ramp_q <= ramp_d;
            d1_q   <= ramp_d;
        end
    end
`else
    // Sample register: ADC data captured every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q <= {DATA_W{1'b0}};
        end else begin
            d1_q <= adc_data;
        end
    end
`endif

    // Next-state logic: arming, trigger wait, capture countdown, lock-loss abort.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        overflow_d = overflow_q;
        lock_err_d = lock_err_q;
        push_try_s = 1'b0;
        arm_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && lock_q) begin
                    if (num_samples != {CNT_W{1'b0}}) begin
                        state_d    = ST_ARMED;
                        cnt_d      = num_samples;
                        overflow_d = 1'b0;
                        lock_err_d = 1'b0;
                        arm_s      = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!lock_q) begin
                    state_d    = ST_IDLE;
                    lock_err_d = 1'b1;
                end else if (trig_rise_s) begin
                    state_d = ST_ACQ;
                    rem_d   = cnt_q;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ACQ: begin
                if (!lock_q) begin
                    state_d    = ST_IDLE;
                    lock_err_d = 1'b1;
                end else begin
                    push_try_s = 1'b1;
                    rem_d      = rem_q - REM_ONE;
                    if (!space_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, sticky flags and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rem_q      <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            lock_err_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            overflow_q <= overflow_d;
            lock_err_q <= lock_err_d;
            busy_q     <= (state_d == ST_ARMED) || (state_d == ST_ACQ);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {FIFO_AW{1'b0}};
            rd_ptr_q <= {FIFO_AW{1'b0}};
            count_q  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage: {last, data}; the last flag marks the final sample of a run.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= {(rem_q == REM_ONE), d1_q};
        end
    end

    assign m_valid  = (count_q != {(FIFO_AW+1){1'b0}});
    assign m_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign m_last   = m_valid & mem_q[rd_ptr_q][DATA_W];
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign lock_err = lock_err_q;

endmodule
